// File: rtl/demux_write_bank_16x20.sv
// ---------------------------------------------------------------------------
// demux_write_bank_16x20
//
// Write-side companion of the 16-way read multiplexor. A 4-bit address steers
// a DATA_W-bit write into one of sixteen holding registers. All sixteen are
// presented in parallel on q so they can drive the mux inputs directly
// (word 0 -> input a ... word 15 -> input p).
//
// Two ways to write:
//   * single beats in IDLE, addressed by wr_addr
//   * burst fill: burst_start loads a base pointer and a beat count, and each
//     accepted beat writes the pointed register and advances the pointer
//     (wrapping 15 -> 0) until the count runs out
//
// Ports:
//   clk          system clock, rising-edge
//   rst          synchronous active-high reset
//   wr_valid     write beat offered
//   wr_ready     beat accepted this cycle when wr_valid is also high
//   wr_addr      target of single writes (ignored during a burst)
//   wr_data      write data
//   burst_start  burst request, only looked at in IDLE
//   burst_base   first register of the burst
//   burst_len    beat count 1..16 (0 = no-op, 17..31 treated as 16)
//   busy         high while a burst is in progress
//   burst_done   one-cycle pulse after the final burst beat is taken
//   q            all registers flattened, word k at q[DATA_W*k +: DATA_W]
//
// Optional build macro:
//   DEMUX_REG0_ZERO_EN  when defined, register 0 is hardwired to zero. Writes
//                       to it are still handshaked and still advance a burst,
//                       but the data is dropped.
// ---------------------------------------------------------------------------
module demux_write_bank_16x20 #(
    parameter int                 DATA_W    = 20,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [3:0]             wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   burst_start,
    input  logic [3:0]             burst_base,
    input  logic [4:0]             burst_len,
    output logic                   busy,
    output logic                   burst_done,
    output logic [16*DATA_W-1:0]   q
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [DATA_W-1:0]  regs [16];
    logic [3:0]         ptr;
    logic [4:0]         remaining;

    logic               burst_load;
    logic               last_beat;
    logic [4:0]         len_sat;
    logic               wr_en;
    logic [3:0]         wr_idx;

    // Any length with bit 4 set is 16 or more, so clamp all of those to 16.
    assign len_sat    = burst_len[4] ? 5'd16 : burst_len;

    // A zero-length request is swallowed in IDLE without starting anything.
    assign burst_load = (state == IDLE) && burst_start && (burst_len != 5'd0);

    // The beat that empties the counter ends the burst.
    assign last_beat  = (state == BURST) && wr_valid && (remaining == 5'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (burst_load) begin
                    next_state = BURST;
                end
            end
            BURST: begin
                if (last_beat) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output and write-steering logic. In IDLE a pending burst_start holds off
    // the single write, so the start cycle never also writes a register.
    always_comb begin
        wr_ready = 1'b0;
        busy     = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = wr_addr;
        case (state)
            IDLE: begin
                wr_ready = !burst_start;
                wr_en    = wr_valid && !burst_start;
                wr_idx   = wr_addr;
            end
            BURST: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
                wr_en    = wr_valid;
                wr_idx   = ptr;
            end
            default: begin
                wr_ready = 1'b0;
            end
        endcase
    end

    // Burst pointer, beat counter and the completion pulse. burst_done is
    // cleared every cycle by default so it is a single-cycle pulse, and a
    // reset on the last beat wins over the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= 4'd0;
            remaining  <= 5'd0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            if (burst_load) begin
                ptr       <= burst_base;
                remaining <= len_sat;
            end else if (state == BURST && wr_valid) begin
                ptr       <= ptr + 4'd1;
                remaining <= remaining - 5'd1;
                if (last_beat) begin
                    burst_done <= 1'b1;
                end
            end
        end
    end

    // Register bank. Only the addressed word is loaded; everything else holds.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 16; k++) begin
            if (rst) begin
`ifdef DEMUX_REG0_ZERO_EN
                regs[k] <= (k == 0) ? '0 : RESET_VAL;
`else
                regs[k] <= RESET_VAL;
`endif
            end else if (wr_en && (wr_idx == 4'(k))) begin
`ifdef DEMUX_REG0_ZERO_EN
                if (k != 0) begin
                    regs[k] <= wr_data;
                end
`else
                regs[k] <= wr_data;
`endif
            end
        end
    end

    // Flatten the bank onto q.
    always_comb begin
        q = '0;
        for (int k = 0; k < 16; k++) begin
            q[DATA_W*k +: DATA_W] = regs[k];
        end
    end

endmodule

// File: tb/tb_demux_write_bank_16x20.sv
// ---------------------------------------------------------------------------
// tb_demux_write_bank_16x20
//
// Self-checking bench for demux_write_bank_16x20. A behavioural model keeps
// the sixteen words as a plain array plus a burst pointer and beat count, and
// every clock the DUT's q, busy, burst_done and wr_ready are compared with it.
// Directed steps follow the intended use cases; random data and addresses
// fill in the values.
// ---------------------------------------------------------------------------
module tb_demux_write_bank_16x20;

    localparam int DW = 20;

    logic              clock;
    logic              reset;
    logic              wrValid;
    logic              wrReady;
    logic [3:0]        wrAddr;
    logic [DW-1:0]     wrData;
    logic              burstStart;
    logic [3:0]        burstBase;
    logic [4:0]        burstLen;
    logic              busy;
    logic              burstDone;
    logic [16*DW-1:0]  q;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the bank.
    logic [DW-1:0] mdlRegs [16];
    bit            mdlBusy;
    int            mdlPtr;
    int            mdlLeft;
    bit            mdlDone;
    int            doneCount;

    demux_write_bank_16x20 dut (
        .clk         (clock),
        .rst         (reset),
        .wr_valid    (wrValid),
        .wr_ready    (wrReady),
        .wr_addr     (wrAddr),
        .wr_data     (wrData),
        .burst_start (burstStart),
        .burst_base  (burstBase),
        .burst_len   (burstLen),
        .busy        (busy),
        .burst_done  (burstDone),
        .q           (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model write honouring the optional hardwired-zero word 0.
    function automatic void modelWrite(input int idx, input logic [DW-1:0] data);
`ifdef DEMUX_REG0_ZERO_EN
        if (idx != 0) mdlRegs[idx] = data;
`else
        mdlRegs[idx] = data;
`endif
    endfunction

    function automatic logic [16*DW-1:0] packModel();
        logic [16*DW-1:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[DW*k +: DW] = mdlRegs[k];
        return v;
    endfunction

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input int idx, input logic [DW-1:0] exp);
        logic [DW-1:0] obs;
        obs = q[DW*idx +: DW];
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s word%0d observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    // Compare all registered outputs against the model after an edge.
    task automatic checkOutput(input string tag);
        logic [16*DW-1:0] expQ;
        expQ = packModel();
        checks++;
        assert (q === expQ) else begin
            failures++;
            $error("[TB] FAIL %s q observed=%h expected=%h", tag, q, expQ);
        end
        checkBit({tag, " busy"}, busy, mdlBusy);
        checkBit({tag, " burst_done"}, burstDone, mdlDone);
    endtask

    // One clock cycle: drive inputs, check the combinational ready, advance
    // the model by the behavioural rules, clock the DUT and compare.
    task automatic applyStimulus(input string tag, input logic rstIn, input logic valid,
                                 input logic [3:0] addr, input logic [DW-1:0] data,
                                 input logic start, input logic [3:0] base,
                                 input logic [4:0] len);
        bit expReady;
        reset      = rstIn;
        wrValid    = valid;
        wrAddr     = addr;
        wrData     = data;
        burstStart = start;
        burstBase  = base;
        burstLen   = len;
        #2;
        expReady = mdlBusy ? 1'b1 : !start;
        if (!rstIn) checkBit({tag, " wr_ready"}, wrReady, expReady);

        mdlDone = 1'b0;
        if (rstIn) begin
            for (int k = 0; k < 16; k++) mdlRegs[k] = '0;
            mdlBusy = 1'b0;
            mdlPtr  = 0;
            mdlLeft = 0;
        end else if (!mdlBusy) begin
            if (start) begin
                if (len != 0) begin
                    mdlBusy = 1'b1;
                    mdlPtr  = base;
                    mdlLeft = (len > 16) ? 16 : int'(len);
                end
            end else if (valid) begin
                modelWrite(addr, data);
            end
        end else if (valid) begin
            modelWrite(mdlPtr, data);
            mdlPtr  = (mdlPtr + 1) % 16;
            mdlLeft = mdlLeft - 1;
            if (mdlLeft == 0) begin
                mdlBusy = 1'b0;
                mdlDone = 1'b1;
            end
        end
        if (mdlDone) doneCount++;

        @(posedge clock);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int    beat;
        int    startDone;
        logic [DW-1:0] expWord;

        reset = 1'b1; wrValid = 1'b0; wrAddr = '0; wrData = '0;
        burstStart = 1'b0; burstBase = '0; burstLen = '0;
        mdlBusy = 1'b0; mdlPtr = 0; mdlLeft = 0; mdlDone = 1'b0; doneCount = 0;
        for (int k = 0; k < 16; k++) mdlRegs[k] = 'x;

        // Reset
        applyStimulus("reset0", 1, 0, 0, 0, 0, 0, 0);
        applyStimulus("reset1", 1, 1, 4'd3, 20'h55555, 0, 0, 0);
        for (int k = 0; k < 16; k++) checkWord("reset", k, 20'h0);

        // Single writes
        applyStimulus("single3",  0, 1, 4'd3,  20'hABCDE, 0, 0, 0);
        applyStimulus("single15", 0, 1, 4'd15, 20'h00001, 0, 0, 0);
        checkWord("single", 3, 20'hABCDE);
        checkWord("single", 15, 20'h00001);
        checkWord("single", 0, 20'h0);

        // Burst base 14 len 4, gap after beat 2
        startDone = doneCount;
        applyStimulus("b4start", 0, 0, 0, 0, 1, 4'd14, 5'd4);
        applyStimulus("b4beat1", 0, 1, 4'd9, 20'd1, 0, 0, 0);
        applyStimulus("b4beat2", 0, 1, 4'd9, 20'd2, 1, 4'd3, 5'd7);
        applyStimulus("b4gap",   0, 0, 4'd9, 20'hFFFFF, 0, 0, 0);
        applyStimulus("b4beat3", 0, 1, 4'd9, 20'd3, 0, 0, 0);
        applyStimulus("b4beat4", 0, 1, 4'd9, 20'd4, 0, 0, 0);
        applyStimulus("b4after", 0, 0, 0, 0, 0, 0, 0);
        checkWord("b4", 14, 20'd1);
        checkWord("b4", 15, 20'd2);
        checkWord("b4", 1, 20'd4);
        checkBit("b4 single done pulse", (doneCount - startDone) == 1, 1'b1);

        // burst_start together with a single write: write is blocked
        applyStimulus("collide", 0, 1, 4'd5, 20'h12345, 1, 4'd8, 5'd2);
        checkWord("collide", 5, 20'h0);
        applyStimulus("c2beat1", 0, 1, 0, $urandom, 0, 0, 0);
        // Last beat, then restart on the burst_done cycle (back-to-back)
        applyStimulus("c2beat2", 0, 1, 0, $urandom, 0, 0, 0);
        applyStimulus("b2bstart", 0, 0, 0, 0, 1, 4'd10, 5'd1);
        applyStimulus("b2bbeat", 0, 1, 0, 20'h0BEEF, 0, 0, 0);
        checkWord("b2b", 10, 20'h0BEEF);

        // Zero-length burst request is a no-op
        applyStimulus("len0", 0, 1, 4'd6, 20'h77777, 1, 4'd6, 5'd0);
        applyStimulus("len0after", 0, 0, 0, 0, 0, 0, 0);

        // Full 16-beat burst from 7 with random wr_addr noise
        applyStimulus("b16start", 0, 0, 0, 0, 1, 4'd7, 5'd16);
        for (int i = 0; i < 16; i++) begin
            applyStimulus("b16beat", 0, 1, 4'($urandom_range(0, 15)),
                          DW'(i + 100), 0, 0, 0);
        end
        applyStimulus("b16after", 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k < 16; k++) begin
            expWord = DW'(((k - 7 + 16) % 16) + 100);
            checkWord("b16", k, expWord);
        end

        // Oversized length saturates to 16, random valid gaps
        applyStimulus("b25start", 0, 0, 0, 0, 1, 4'd0, 5'd25);
        beat = 0;
        for (int i = 0; i < 40 && beat < 17; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                applyStimulus("b25beat", 0, 1, 0, DW'($urandom), 0, 0, 0);
                beat++;
            end else begin
                applyStimulus("b25stall", 0, 0, 0, DW'($urandom), 0, 0, 0);
            end
        end

        // Reset mid-burst
        startDone = doneCount;
        applyStimulus("b8start", 0, 0, 0, 0, 1, 4'd2, 5'd8);
        for (int i = 0; i < 3; i++) applyStimulus("b8beat", 0, 1, 0, DW'($urandom), 0, 0, 0);
        applyStimulus("b8reset", 1, 1, 0, DW'($urandom), 0, 0, 0);
        applyStimulus("b8idle", 0, 0, 0, 0, 0, 0, 0);
        checkBit("b8 no done pulse", (doneCount - startDone) == 0, 1'b1);

        // Random single writes
        for (int i = 0; i < 12; i++) begin
            applyStimulus("rand", 0, 1'($urandom), 4'($urandom), DW'($urandom), 0, 0, 0);
        end

        // Register 0 handling
        applyStimulus("w0", 0, 1, 4'd0, 20'hFFFFF, 0, 0, 0);
        applyStimulus("z2start", 0, 0, 0, 0, 1, 4'd15, 5'd2);
        applyStimulus("z2beat1", 0, 1, 0, 20'h0F0F0, 0, 0, 0);
        applyStimulus("z2beat2", 0, 1, 0, 20'h0A0A0, 0, 0, 0);
        applyStimulus("z2after", 0, 0, 0, 0, 0, 0, 0);
        checkWord("z2", 15, 20'h0F0F0);
`ifdef DEMUX_REG0_ZERO_EN
        checkWord("z2", 0, 20'h0);
`else
        checkWord("z2", 0, 20'h0A0A0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_write_bank_16x20.md
Name: demux_write_bank_16x20

Overview:
- Write-side counterpart of the 16-way 20-bit read multiplexor.
- Decodes a 4-bit address and steers a 20-bit write into one of 16 holding registers.
- All 16 registers are exposed in parallel so they can feed the read multiplexor's sixteen inputs directly.
- Supports single addressed writes and an auto-incrementing burst-fill mode with a valid/ready handshake.

Parameters:
DATA_W, 20, width of each register word
RESET_VAL, 0, value loaded into every register on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
wr_valid  input  1  write beat offered
wr_ready  output  1  write beat can be accepted this cycle
wr_addr  input  4  target register for single writes; ignored during burst
wr_data  input  DATA_W  write data
burst_start  input  1  request a burst fill (sampled in IDLE only)
burst_base  input  4  first register of the burst
burst_len  input  5  beats in the burst, 1..16; 0 = no-op
busy  output  1  high while in BURST
burst_done  output  1  one-cycle pulse after the last burst beat is accepted
q  output  16*DATA_W  all registers flattened; register k at q[DATA_W*k +: DATA_W], k=0 maps to mux input a, k=15 maps to mux input p

Behaviour:
- Reset values on rst=1 at a clock edge:
  - all 16 registers = RESET_VAL
  - state = IDLE, ptr = 0, remaining = 0
  - busy = 0, burst_done = 0
  - wr_ready is combinational and equals 1 in IDLE when burst_start = 0.
- A beat is accepted on a cycle where wr_valid & wr_ready.
  - Accepted data is visible on q on the next cycle (1-cycle latency).
  - All non-targeted registers hold their value.
- IDLE state:
  - wr_ready = !burst_start.
  - An accepted beat writes reg[wr_addr].
  - If burst_start = 1 and burst_len != 0: load ptr = burst_base and remaining = burst_len, then go to BURST. No write occurs that cycle, even if wr_valid = 1.
  - If burst_start = 1 and burst_len = 0: stay in IDLE, no write, no burst_done.
- BURST state:
  - busy = 1, wr_ready = 1.
  - Each accepted beat writes reg[ptr], then ptr = ptr + 1 modulo 16 (15 wraps to 0), and remaining decrements.
  - The beat accepted while remaining = 1 returns the block to IDLE and sets burst_done = 1 on the following cycle only.
  - A cycle with wr_valid = 0 stalls: no change.
  - burst_start and wr_addr are ignored in BURST.
- burst_len = 16 with any base writes every register exactly once, wrapping through 15→0.
- Lengths above 16 (17..31) are saturated to 16.
- rst asserted mid-burst aborts the burst on that edge: registers return to RESET_VAL, state = IDLE, and no burst_done pulse is generated.
- Back-to-back bursts: a new burst_start is accepted on the first IDLE cycle, which is the same cycle burst_done is high.

Optional Feature:
- Macro: DEMUX_REG0_ZERO_EN.
- Defined:
  - register 0 is hardwired to 0, including at reset.
  - Writes addressed to 0 (single or burst) are accepted: wr_ready behaviour is unchanged and ptr/remaining still advance, but the data is discarded.
  - q[DATA_W-1:0] is always 0.
- Undefined: register 0 behaves like every other register.

Test Plan:
- Reset, then single writes 20'hABCDE→addr 3 and 20'h00001→addr 15 → next cycle q word3=ABCDE, word15=00001, all other words = 0, busy = 0 throughout.
- Burst base=14, len=4, data 1,2,3,4 with a one-cycle wr_valid gap after beat 2 → words 14,15,0,1 = 1,2,3,4. burst_done pulses exactly once, on the cycle after beat 4. busy is high from the cycle after start through beat 4. The gap changes nothing.
- burst_start=1 and wr_valid=1 (addr 5, data 20'h12345) in the same IDLE cycle → wr_ready=0, word5 unchanged, busy=1 next cycle. burst_len=0 variant → no state change, no burst_done.
- Burst len=16 base=7, data = index+100 → every word k = ((k−7) mod 16)+100. During the burst wr_addr is toggled randomly and has no effect.
- Burst len=8, rst asserted after 3 beats → all words = 0 next cycle, busy=0, no burst_done, wr_ready=1.
- DEMUX_REG0_ZERO_EN defined: single write 20'hFFFFF→addr 0, then burst base=15 len=2 → word0 stays 0, word15 is written, ptr still advances past 0, and burst_done pulses after beat 2.
